rv_divider_unit: RTL and testbench

- Iterative multi-cycle divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits directly downstream of the register file: consumes the two RF read ports (readData1 as dividend, readData2 as divisor) and feeds the quotient or remainder back to the RF write port (writeReg/writeData/writeEnable).
- Uses a radix-2 restoring algorithm, one quotient bit per cycle, with a start/busy/done handshake to the control path.

---
 rtl/rv_divider_unit_if.sv | 26 ++
 rtl/rv_divider_unit.sv | 169 ++++++++++++++++
 tb/tb_rv_divider_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_divider_unit_if.sv
// Handshake and operand/result bundle between control path, register file and the RV32M divider.
interface rv_divider_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            kill;
  logic [1:0]      funct;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic [4:0]      destRegIn;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      destReg;
  logic            writeEnable;

  modport master (
    output start, kill, funct, operandA, operandB, destRegIn,
    input  busy, done, result, destReg, writeEnable
  );

  modport slave (
    input  start, kill, funct, operandA, operandB, destRegIn,
    output busy, done, result, destReg, writeEnable
  );
endinterface

// File: rtl/rv_divider_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// start/busy/done handshake, result and destination index feed the RF write port.
module rv_divider_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic              clk,
  input logic              areset,
  rv_divider_unit_if.slave divBus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  logic [1:0]       state,      stateNext;
  logic [CNT_W-1:0] cnt,        cntNext;
  logic [XLEN:0]    remReg,     remNext;
  logic [XLEN-1:0]  quoReg,     quoNext;
  logic [XLEN-1:0]  divisorReg, divisorNext;
  logic             remSel,     remSelNext;
  logic             negQuo,     negQuoNext;
  logic             negRem,     negRemNext;
  logic [4:0]       destHold,   destHoldNext;
  logic [XLEN-1:0]  resultReg,  resultNext;
  logic [4:0]       destRegReg, destRegNext;
  logic             busyReg,    busyNext;
  logic             doneReg,    doneNext;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  logic [XLEN:0]   remShift;
  logic [XLEN:0]   trialDiff;
  logic            borrow;
  logic [XLEN-1:0] stepQuo;
  logic [XLEN:0]   stepRem;
  logic [XLEN-1:0] finalQuo;
  logic [XLEN-1:0] finalRem;

  assign remShift  = (remReg << 1) | (XLEN+1)'(quoReg[XLEN-1]);
  assign trialDiff = remShift - {1'b0, divisorReg};
  assign borrow    = trialDiff[XLEN];
  assign stepQuo   = {quoReg[XLEN-2:0], ~borrow};
  assign stepRem   = borrow ? remShift : trialDiff;
  assign finalQuo  = negQuo ? (~stepQuo + XLEN'(1)) : stepQuo;
  assign finalRem  = negRem ? (~stepRem[XLEN-1:0] + XLEN'(1)) : stepRem[XLEN-1:0];

  // Operand conditioning at capture: magnitudes and sign flags for the signed ops.
  logic            isSigned;
  logic            negA;
  logic            negB;
  logic [XLEN-1:0] absA;
  logic [XLEN-1:0] absB;
  logic            divByZero;
  logic            overflow;

  assign isSigned  = ~divBus.funct[0];
  assign negA      = isSigned & divBus.operandA[XLEN-1];
  assign negB      = isSigned & divBus.operandB[XLEN-1];
  assign absA      = negA ? (~divBus.operandA + XLEN'(1)) : divBus.operandA;
  assign absB      = negB ? (~divBus.operandB + XLEN'(1)) : divBus.operandB;
  assign divByZero = (divBus.operandB == '0);
  assign overflow  = isSigned && (divBus.operandA == INT_MIN) && (divBus.operandB == ALL_ONES);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      cnt        <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      remSel     <= 1'b0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      destHold   <= '0;
      resultReg  <= '0;
      destRegReg <= '0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      remReg     <= remNext;
      quoReg     <= quoNext;
      divisorReg <= divisorNext;
      remSel     <= remSelNext;
      negQuo     <= negQuoNext;
      negRem     <= negRemNext;
      destHold   <= destHoldNext;
      resultReg  <= resultNext;
      destRegReg <= destRegNext;
      busyReg    <= busyNext;
      doneReg    <= doneNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    remNext      = remReg;
    quoNext      = quoReg;
    divisorNext  = divisorReg;
    remSelNext   = remSel;
    negQuoNext   = negQuo;
    negRemNext   = negRem;
    destHoldNext = destHold;
    resultNext   = resultReg;
    destRegNext  = destRegReg;

    case (state)
      IDLE: begin
        if (divBus.start) begin
          remSelNext   = divBus.funct[1];
          negQuoNext   = negA ^ negB;
          negRemNext   = negA;
          destHoldNext = divBus.destRegIn;
          if (divByZero) begin
            resultNext  = divBus.funct[1] ? divBus.operandA : ALL_ONES;
            destRegNext = divBus.destRegIn;
            stateNext   = DONE;
          end else if (overflow) begin
            resultNext  = divBus.funct[1] ? '0 : INT_MIN;
            destRegNext = divBus.destRegIn;
            stateNext   = DONE;
          end else begin
            cntNext     = '0;
            remNext     = '0;
            quoNext     = absA;
            divisorNext = absB;
            stateNext   = CALC;
          end
        end
      end
      CALC: begin
        if (divBus.kill) begin
          stateNext = IDLE;
        end else begin
          quoNext = stepQuo;
          remNext = stepRem;
          cntNext = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            resultNext  = remSel ? finalRem : finalQuo;
            destRegNext = destHold;
            stateNext   = DONE;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == DONE);
  end

  assign divBus.busy        = busyReg;
  assign divBus.done        = doneReg;
  assign divBus.writeEnable = doneReg;
  assign divBus.result      = resultReg;
  assign divBus.destReg     = destRegReg;

endmodule

// File: tb/tb_rv_divider_unit.sv
// Directed, table-driven bench for rv_divider_unit plus hand sequences for
// reset, ignored start, kill and start-with-kill corner cases.
module tb_rv_divider_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] F_DIV  = 2'd0;
  localparam logic [1:0] F_DIVU = 2'd1;
  localparam logic [1:0] F_REM  = 2'd2;
  localparam logic [1:0] F_REMU = 2'd3;
  localparam int LAT_CALC = 32;
  localparam int LAT_SPEC = 0;
  localparam int BUDGET   = 40;

  typedef struct {
    logic [1:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] expRes;
    int          expLat;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic areset;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv_divider_unit_if #(.XLEN(XLEN)) divBus();

  rv_divider_unit #(.XLEN(XLEN), .CNT_W(5)) dut (
    .clk    (clk),
    .areset (areset),
    .divBus (divBus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present an op at the falling edge; e0 is the cycle stamp of the accepting edge.
  task automatic startOp(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic killToo, output int e0);
    @(negedge clk);
    divBus.funct     = f;
    divBus.operandA  = a;
    divBus.operandB  = b;
    divBus.destRegIn = dest;
    divBus.start     = 1'b1;
    divBus.kill      = killToo;
    @(posedge clk);
    #1;
    e0 = cyc;
    divBus.start = 1'b0;
    divBus.kill  = 1'b0;
  endtask

  task automatic waitDone(input int e0, output int lat);
    while (divBus.done !== 1'b1 && (cyc - e0) < BUDGET) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - e0;
  endtask

  task automatic checkCompletion(input string name, input int e0, input int expLat,
                                 input logic [31:0] expRes, input logic [4:0] expDest);
    int lat;
    waitDone(e0, lat);
    check({name, " latency"}, 32'(lat), 32'(expLat));
    check({name, " result"}, divBus.result, expRes);
    check({name, " destReg"}, 32'(divBus.destReg), 32'(expDest));
    check({name, " writeEnable"}, 32'(divBus.writeEnable), 32'd1);
    check({name, " busy in DONE"}, 32'(divBus.busy), 32'd1);
    @(posedge clk);
    #1;
    check({name, " done pulse ends"}, 32'(divBus.done), 32'd0);
    check({name, " writeEnable ends"}, 32'(divBus.writeEnable), 32'd0);
    check({name, " busy ends"}, 32'(divBus.busy), 32'd0);
    check({name, " result holds"}, divBus.result, expRes);
  endtask

  // Watch a window of cycles and report how many had done asserted.
  task automatic countDone(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (divBus.done === 1'b1) seen++;
    end
  endtask

  vec_t vecs[18];

  initial begin
    int e0;
    int seen;

    vecs[0]  = '{F_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         LAT_CALC, "DIVU 100/7"};
    vecs[1]  = '{F_REMU, 32'd100,        32'd7,          5'd6,  32'd2,          LAT_CALC, "REMU 100/7"};
    vecs[2]  = '{F_DIV,  32'hFFFFFFF9,   32'd2,          5'd7,  32'hFFFFFFFD,   LAT_CALC, "DIV -7/2"};
    vecs[3]  = '{F_REM,  32'hFFFFFFF9,   32'd2,          5'd8,  32'hFFFFFFFF,   LAT_CALC, "REM -7/2"};
    vecs[4]  = '{F_DIV,  32'd7,          32'hFFFFFFFE,   5'd9,  32'hFFFFFFFD,   LAT_CALC, "DIV 7/-2"};
    vecs[5]  = '{F_REM,  32'd7,          32'hFFFFFFFE,   5'd10, 32'd1,          LAT_CALC, "REM 7/-2"};
    vecs[6]  = '{F_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd11, 32'd14,         LAT_CALC, "DIV -100/-7"};
    vecs[7]  = '{F_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd12, 32'hFFFFFFFE,   LAT_CALC, "REM -100/-7"};
    vecs[8]  = '{F_DIVU, 32'h00001234,   32'd0,          5'd13, 32'hFFFFFFFF,   LAT_SPEC, "DIVU x/0"};
    vecs[9]  = '{F_REM,  32'h00001234,   32'd0,          5'd14, 32'h00001234,   LAT_SPEC, "REM x/0"};
    vecs[10] = '{F_DIV,  32'hFFFFFFF0,   32'd0,          5'd15, 32'hFFFFFFFF,   LAT_SPEC, "DIV -16/0"};
    vecs[11] = '{F_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd16, 32'h80000000,   LAT_SPEC, "DIV overflow"};
    vecs[12] = '{F_REM,  32'h80000000,   32'hFFFFFFFF,   5'd17, 32'd0,          LAT_SPEC, "REM overflow"};
    vecs[13] = '{F_DIVU, 32'h80000000,   32'hFFFFFFFF,   5'd18, 32'd0,          LAT_CALC, "DIVU min/max"};
    vecs[14] = '{F_DIV,  32'h80000000,   32'd1,          5'd19, 32'h80000000,   LAT_CALC, "DIV min/1"};
    vecs[15] = '{F_REM,  32'h80000000,   32'd3,          5'd20, 32'hFFFFFFFE,   LAT_CALC, "REM min/3"};
    vecs[16] = '{F_REMU, 32'd5,          32'd9,          5'd21, 32'd5,          LAT_CALC, "REMU 5/9"};
    vecs[17] = '{F_DIVU, 32'hFFFFFFFF,   32'd1,          5'd31, 32'hFFFFFFFF,   LAT_CALC, "DIVU max/1"};

    areset           = 1'b1;
    divBus.start     = 1'b0;
    divBus.kill      = 1'b0;
    divBus.funct     = 2'd0;
    divBus.operandA  = '0;
    divBus.operandB  = '0;
    divBus.destRegIn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(divBus.busy), 32'd0);
    check("reset done", 32'(divBus.done), 32'd0);
    check("reset writeEnable", 32'(divBus.writeEnable), 32'd0);
    check("reset result", divBus.result, 32'd0);
    check("reset destReg", 32'(divBus.destReg), 32'd0);
    @(negedge clk);
    areset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      startOp(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].dest, 1'b0, e0);
      checkCompletion(vecs[i].name, e0, vecs[i].expLat, vecs[i].expRes, vecs[i].dest);
    end

    // Reset mid-CALC discards the operation and clears the outputs at once.
    startOp(F_DIVU, 32'd100, 32'd7, 5'd5, 1'b0, e0);
    repeat (10) @(posedge clk);
    #1;
    check("midcalc busy before reset", 32'(divBus.busy), 32'd1);
    areset = 1'b1;
    #1;
    check("midcalc reset busy", 32'(divBus.busy), 32'd0);
    check("midcalc reset done", 32'(divBus.done), 32'd0);
    check("midcalc reset writeEnable", 32'(divBus.writeEnable), 32'd0);
    check("midcalc reset result", divBus.result, 32'd0);
    check("midcalc reset destReg", 32'(divBus.destReg), 32'd0);
    @(negedge clk);
    areset = 1'b0;
    countDone(BUDGET, seen);
    check("no done after reset", 32'(seen), 32'd0);

    // A second start during CALC is ignored; original op completes on schedule.
    startOp(F_DIVU, 32'd100, 32'd7, 5'd5, 1'b0, e0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    divBus.funct     = F_DIVU;
    divBus.operandA  = 32'd9;
    divBus.operandB  = 32'd3;
    divBus.destRegIn = 5'd9;
    divBus.start     = 1'b1;
    @(negedge clk);
    divBus.start = 1'b0;
    checkCompletion("ignored start", e0, LAT_CALC, 32'd14, 5'd5);

    // Kill during CALC: back to IDLE, no completion.
    startOp(F_DIVU, 32'd100, 32'd7, 5'd4, 1'b0, e0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    divBus.kill = 1'b1;
    @(posedge clk);
    #1;
    divBus.kill = 1'b0;
    check("kill busy", 32'(divBus.busy), 32'd0);
    check("kill result untouched", divBus.result, 32'd14);
    countDone(BUDGET, seen);
    check("no done after kill", 32'(seen), 32'd0);

    startOp(F_DIVU, 32'd9, 32'd3, 5'd3, 1'b0, e0);
    checkCompletion("DIVU 9/3 after kill", e0, LAT_CALC, 32'd3, 5'd3);

    // start with kill in IDLE: start wins.
    startOp(F_DIVU, 32'd50, 32'd5, 5'd2, 1'b1, e0);
    checkCompletion("start+kill in IDLE", e0, LAT_CALC, 32'd10, 5'd2);

    // start with kill on a special case: still completes in one cycle.
    startOp(F_REMU, 32'hDEADBEEF, 32'd0, 5'd1, 1'b1, e0);
    checkCompletion("REMU x/0 with kill", e0, LAT_SPEC, 32'hDEADBEEF, 5'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
